// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions: bubble instruction, fetch FSM encoding, IF/ID field widths.
package if_stage_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned PC_W   = 32;

    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DISCARD = 2'd1,
        HOLD    = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } fetch_buf_t;

    // Instruction addresses are word aligned; low two bits are dropped.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// Pipeline register with async reset, flush-to-bubble (highest priority), load and hold.
module if_id_reg #(
    parameter logic [31:0] NOP_INST = if_stage_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] d_inst,
    input  logic [31:0] d_pc,
    input  logic        d_valid,
    output logic [31:0] q_inst,
    output logic [31:0] q_pc,
    output logic        q_valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_inst  <= NOP_INST;
            q_pc    <= '0;
            q_valid <= 1'b0;
        end else if (flush) begin
            q_inst  <= NOP_INST;
            q_pc    <= '0;
            q_valid <= 1'b0;
        end else if (load) begin
            q_inst  <= d_inst;
            q_pc    <= d_pc;
            q_valid <= d_valid;
        end
    end

endmodule

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: owns the PC, single-outstanding imem requests, IF/ID register.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = if_stage_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid,
    output logic        fetch_busy_o
);

    import if_stage_pkg::*;

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] tgt_q, tgt_d;
    fetch_buf_t      buf_q, buf_d;

    logic [PC_W-1:0]   redirect_pc;
    logic [PC_W-1:0]   pc_inc;
    logic              id_load;
    logic              id_bubble;
    logic [INST_W-1:0] id_inst_d;
    logic [PC_W-1:0]   id_pc_d;

    assign redirect_pc = align_pc(redirect_pc_i);
    assign pc_inc      = pc_q + PC_W'(4);

    // State, PC, redirect target and stall buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            tgt_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            buf_q   <= buf_d;
        end
    end

    // Next-state and IF/ID control; a redirect always squashes IF/ID on the same edge.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        tgt_d     = tgt_q;
        buf_d     = buf_q;
        id_load   = 1'b0;
        id_bubble = 1'b0;
        id_inst_d = imem_rdata_i;
        id_pc_d   = pc_q;

        case (state_q)
            FETCH: begin
                if (redirect_i) begin
                    id_bubble = 1'b1;
                    if (imem_ack_i) begin
                        pc_d = redirect_pc;
                    end else begin
                        tgt_d   = redirect_pc;
                        state_d = DISCARD;
                    end
                end else if (imem_ack_i) begin
                    pc_d = pc_inc;
                    if (stall_i) begin
                        buf_d   = '{inst: imem_rdata_i, pc: pc_q};
                        state_d = HOLD;
                    end else begin
                        id_load = 1'b1;
                    end
                end else if (!stall_i) begin
                    id_bubble = 1'b1;
                end
            end

            // Old request is still outstanding: wait for its ack, then drop the data.
            DISCARD: begin
                id_bubble = 1'b1;
                if (imem_ack_i) begin
                    pc_d    = redirect_i ? redirect_pc : tgt_q;
                    state_d = FETCH;
                end else if (redirect_i) begin
                    tgt_d = redirect_pc;
                end
            end

            HOLD: begin
                if (redirect_i) begin
                    pc_d      = redirect_pc;
                    id_bubble = 1'b1;
                    state_d   = FETCH;
                end else if (!stall_i) begin
                    id_load   = 1'b1;
                    id_inst_d = buf_q.inst;
                    id_pc_d   = buf_q.pc;
                    state_d   = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    if_id_reg #(
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .load    (id_load),
        .flush   (flush_i | id_bubble),
        .d_inst  (id_inst_d),
        .d_pc    (id_pc_d),
        .d_valid (1'b1),
        .q_inst  (if_id_inst),
        .q_pc    (if_id_pc),
        .q_valid (if_id_valid)
    );

    // Request is a decode of state so a 0-wait memory can ack in the cycle it rises.
    assign imem_req_o   = !rst && (state_q != HOLD);
    assign imem_addr_o  = pc_q;
    assign fetch_busy_o = (state_q != FETCH);

endmodule

// File: tb/tb_if_stage.sv
// Directed table-driven bench for if_stage; the bench plays instruction memory via imem_ack_i.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc;
    logic        if_id_valid;
    logic        fetch_busy_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        redir;
        logic [31:0] rpc;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_busy;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic        e_valid;
    } vec_t;

    vec_t vecs[$];

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .if_id_inst    (if_id_inst),
        .if_id_pc      (if_id_pc),
        .if_id_valid   (if_id_valid),
        .fetch_busy_o  (fetch_busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                            input logic valid);
        chk({tag, ".inst"},  if_id_inst, inst);
        chk({tag, ".pc"},    if_id_pc, pc);
        chk({tag, ".valid"}, 32'(if_id_valid), 32'(valid));
    endtask

    function automatic vec_t mk(input logic st, input logic fl, input logic rd, input logic [31:0] rpc,
                                input logic ack, input logic [31:0] rdata,
                                input logic e_req, input logic [31:0] e_addr, input logic e_busy,
                                input logic [31:0] e_inst, input logic [31:0] e_pc, input logic e_valid);
        vec_t v;
        v.stall = st; v.flush = fl; v.redir = rd; v.rpc = rpc; v.ack = ack; v.rdata = rdata;
        v.e_req = e_req; v.e_addr = e_addr; v.e_busy = e_busy;
        v.e_inst = e_inst; v.e_pc = e_pc; v.e_valid = e_valid;
        return v;
    endfunction

    // Called at posedge+1: drive inputs, check request side, then IF/ID after the edge.
    task automatic step(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        stall_i = v.stall; flush_i = v.flush; redirect_i = v.redir; redirect_pc_i = v.rpc;
        imem_ack_i = v.ack; imem_rdata_i = v.rdata;
        #1;
        chk({tag, ".req"},  32'(imem_req_o), 32'(v.e_req));
        if (v.e_req) chk({tag, ".addr"}, imem_addr_o, v.e_addr);
        chk({tag, ".busy"}, 32'(fetch_busy_o), 32'(v.e_busy));
        @(posedge clk);
        #1;
        chk_ifid(tag, v.e_inst, v.e_pc, v.e_valid);
    endtask

    task automatic idle_inputs();
        stall_i = 1'b0; flush_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        imem_ack_i = 1'b0; imem_rdata_i = '0;
    endtask

    initial begin
        //          st fl rd rpc            ack rdata         req addr          busy inst          pc            v
        // 0-wait stream, then a 3-cycle stall catching the pc=8 response
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0,        1));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h4,        1, 32'h4,        0, 32'h4,        32'h4,        1));
        vecs.push_back(mk(1, 0, 0, 32'h0,        1, 32'h8,        1, 32'h8,        0, 32'h4,        32'h4,        1));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h4,        32'h4,        1));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h4,        32'h4,        1));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h8,        32'h8,        1));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'hC,        1, 32'hC,        0, 32'hC,        32'hC,        1));
        // 2-cycle memory with redirect to 0x100 while 0x10 is in flight
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h10,       0, NOP,          32'h0,        0));
        vecs.push_back(mk(0, 0, 1, 32'h100,      0, 32'h0,        1, 32'h10,       0, NOP,          32'h0,        0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'hDEAD,     1, 32'h10,       1, NOP,          32'h0,        0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h100,      1, 32'h100,      0, 32'h100,      32'h100,      1));
        // redirect to unaligned 0x203 on the ack cycle
        vecs.push_back(mk(0, 0, 1, 32'h203,      1, 32'hBAD,      1, 32'h104,      0, NOP,          32'h0,        0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h200,      1, 32'h200,      0, 32'h200,      32'h200,      1));
        // flush together with stall in HOLD keeps the buffer
        vecs.push_back(mk(1, 0, 0, 32'h0,        1, 32'h204,      1, 32'h204,      0, 32'h200,      32'h200,      1));
        vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, NOP,          32'h0,        0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, NOP,          32'h0,        0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h204,      32'h204,      1));
        // redirect out of HOLD drops the buffer
        vecs.push_back(mk(1, 0, 0, 32'h0,        1, 32'h208,      1, 32'h208,      0, 32'h204,      32'h204,      1));
        vecs.push_back(mk(1, 0, 1, 32'h300,      0, 32'h0,        0, 32'h0,        1, NOP,          32'h0,        0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h300,      1, 32'h300,      0, 32'h300,      32'h300,      1));
        // DISCARD: latest redirect wins
        vecs.push_back(mk(0, 0, 1, 32'h400,      0, 32'h0,        1, 32'h304,      0, NOP,          32'h0,        0));
        vecs.push_back(mk(0, 0, 1, 32'h500,      0, 32'h0,        1, 32'h304,      1, NOP,          32'h0,        0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h999,      1, 32'h304,      1, NOP,          32'h0,        0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h500,      1, 32'h500,      0, 32'h500,      32'h500,      1));
        // DISCARD: redirect on the ack cycle goes straight to the new target
        vecs.push_back(mk(0, 0, 1, 32'h600,      0, 32'h0,        1, 32'h504,      0, NOP,          32'h0,        0));
        vecs.push_back(mk(0, 0, 1, 32'h700,      1, 32'h777,      1, 32'h504,      1, NOP,          32'h0,        0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h700,      1, 32'h700,      0, 32'h700,      32'h700,      1));
        // flush in FETCH squashes IF/ID but pc still advances
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h704,      1, 32'h704,      0, NOP,          32'h0,        0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h708,      1, 32'h708,      0, 32'h708,      32'h708,      1));
        // stall with no ack holds IF/ID
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h70C,      0, 32'h708,      32'h708,      1));
        // PC wrap at the top of the address space
        vecs.push_back(mk(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0,       1, 32'h70C,      0, NOP,          32'h0,        0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h123,      1, 32'h70C,      1, NOP,          32'h0,        0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0,        1));
        // enter DISCARD ahead of the mid-flight reset
        vecs.push_back(mk(0, 0, 1, 32'h800,      0, 32'h0,        1, 32'h4,        0, NOP,          32'h0,        0));

        // Reset: bubble in IF/ID and no request while rst is high, across a clock edge
        #1 rst = 1'b1;
        #2;
        chk("rst.req", 32'(imem_req_o), 32'd0);
        chk_ifid("rst", NOP, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_edge.req", 32'(imem_req_o), 32'd0);
        chk_ifid("rst_edge", NOP, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst.req",  32'(imem_req_o), 32'd1);
        chk("post_rst.addr", imem_addr_o, 32'h0);
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

        // Async reset in the middle of DISCARD
        #1;
        chk("pre_rst.busy", 32'(fetch_busy_o), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst.req",  32'(imem_req_o), 32'd0);
        chk("mid_rst.busy", 32'(fetch_busy_o), 32'd0);
        chk_ifid("mid_rst", NOP, 32'h0, 1'b0);
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_rel.req",  32'(imem_req_o), 32'd1);
        chk("mid_rst_rel.addr", imem_addr_o, 32'h0);
        @(posedge clk);
        #1;
        chk_ifid("mid_rst_rel", NOP, 32'h0, 1'b0);
        step(mk(0, 0, 0, 32'h0, 1, 32'hCAFE_0000, 1, 32'h0, 0, 32'hCAFE_0000, 32'h0, 1), 100);
        step(mk(0, 0, 0, 32'h0, 1, 32'hCAFE_0004, 1, 32'h4, 0, 32'hCAFE_0004, 32'h4, 1), 101);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
